// File: rtl/dcache_pmem_arb_if.sv
// Request/response bundle between N dcache pmem requesters, the arbiter and the pmem bus.
// Arbiter takes the slave view; the requester/memory side (bench or wrapper) takes the master view.
interface dcache_pmem_arb_if #(
  parameter int NUM_PORTS = 2
);
  logic [4*NUM_PORTS-1:0]  inport_wr_i;
  logic [NUM_PORTS-1:0]    inport_rd_i;
  logic [8*NUM_PORTS-1:0]  inport_len_i;
  logic [32*NUM_PORTS-1:0] inport_addr_i;
  logic [32*NUM_PORTS-1:0] inport_write_data_i;
  logic [NUM_PORTS-1:0]    inport_accept_o;
  logic [NUM_PORTS-1:0]    inport_ack_o;
  logic [NUM_PORTS-1:0]    inport_error_o;
  logic [32*NUM_PORTS-1:0] inport_read_data_o;
  logic [3:0]              outport_wr_o;
  logic                    outport_rd_o;
  logic [7:0]              outport_len_o;
  logic [31:0]             outport_addr_o;
  logic [31:0]             outport_write_data_o;
  logic                    outport_accept_i;
  logic                    outport_ack_i;
  logic                    outport_error_i;
  logic [31:0]             outport_read_data_i;

  modport slave (
    input  inport_wr_i, inport_rd_i, inport_len_i, inport_addr_i, inport_write_data_i,
    output inport_accept_o, inport_ack_o, inport_error_o, inport_read_data_o,
    output outport_wr_o, outport_rd_o, outport_len_o, outport_addr_o, outport_write_data_o,
    input  outport_accept_i, outport_ack_i, outport_error_i, outport_read_data_i
  );

  modport master (
    output inport_wr_i, inport_rd_i, inport_len_i, inport_addr_i, inport_write_data_i,
    input  inport_accept_o, inport_ack_o, inport_error_o, inport_read_data_o,
    input  outport_wr_o, outport_rd_o, outport_len_o, outport_addr_o, outport_write_data_o,
    output outport_accept_i, outport_ack_i, outport_error_i, outport_read_data_i
  );
endinterface

// File: rtl/dcache_pmem_arb.sv
// N:1 pmem arbiter with burst lock and response-ID FIFO; zero-cycle request and response paths.
// Backpressure: grant held until accept_i; pushes stall when FIFO full. DCACHE_PMEM_ARB_RR_EN selects round-robin.
module dcache_pmem_arb_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_dat_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_dat_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      cnt_q;
  logic             do_push, do_pop;

  assign full_o     = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o    = (cnt_q == '0);
  assign head_dat_o = mem_q[rd_ptr_q];
  assign do_push    = push_i & ~full_o;
  assign do_pop     = pop_i & ~empty_o;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
  end
endmodule

module dcache_pmem_arb #(
  parameter int NUM_PORTS   = 2,
  parameter int ID_W        = 1,
  parameter int OUTSTANDING = 4
) (
  input logic               clk,
  input logic               rst_n,
  dcache_pmem_arb_if.slave  pmem
);
  localparam int ENT_W = ID_W + 9;

  logic [NUM_PORTS-1:0] req;
  logic [ID_W-1:0]      rr_ptr, arb_grant, grant, grant_q, grant_d;
  logic                 lock_q, lock_d, locked, arb_found;
  logic [7:0]           burst_cnt_q, burst_cnt_d;
  logic [8:0]           head_cnt_q, head_cnt_d;
  logic                 req_g, rd_g, wr_g, final_wr, would_push, block, fire, push, pop, resp_vld;
  logic [3:0]           sel_wr;
  logic [7:0]           sel_len;
  logic [ENT_W-1:0]     push_dat, head_dat;
  logic                 fifo_full, fifo_empty, head_last;
  logic [ID_W-1:0]      head_id;
  logic [8:0]           head_acks;
  int                   idx;

  always_comb begin
    req = '0;
    for (int p = 0; p < NUM_PORTS; p++)
      req[p] = pmem.inport_rd_i[p] | (|pmem.inport_wr_i[4*p +: 4]);
  end

  // Priority search starts at rr_ptr (always 0 in fixed-priority builds).
  always_comb begin
    arb_grant = '0;
    arb_found = 1'b0;
    idx       = 0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
      if (!arb_found && req[idx]) begin
        arb_grant = ID_W'(idx);
        arb_found = 1'b1;
      end
    end
  end

  assign locked  = lock_q | (burst_cnt_q != 8'd0);
  assign grant   = locked ? grant_q : arb_grant;
  assign req_g   = req[grant];
  assign rd_g    = pmem.inport_rd_i[grant];
  assign sel_wr  = pmem.inport_wr_i[4*grant +: 4];
  assign sel_len = pmem.inport_len_i[8*grant +: 8];
  assign wr_g    = |sel_wr;

  // Only reads and the last beat of a write create a response to track.
  assign final_wr   = wr_g & ((burst_cnt_q == 8'd0) ? (sel_len == 8'd0) : (burst_cnt_q == 8'd1));
  assign would_push = req_g & (rd_g | final_wr);
  assign block      = fifo_full & would_push;
  assign fire       = pmem.outport_accept_i & req_g & ~block;
  assign push       = fire & would_push;
  assign push_dat   = {grant, rd_g ? ({1'b0, sel_len} + 9'd1) : 9'd1};

  always_comb begin
    pmem.outport_wr_o         = '0;
    pmem.outport_rd_o         = 1'b0;
    pmem.outport_len_o        = '0;
    pmem.outport_addr_o       = '0;
    pmem.outport_write_data_o = '0;
    pmem.inport_accept_o      = '0;
    if (req_g) begin
      pmem.outport_wr_o         = block ? 4'd0 : sel_wr;
      pmem.outport_rd_o         = rd_g & ~block;
      pmem.outport_len_o        = sel_len;
      pmem.outport_addr_o       = pmem.inport_addr_i[32*grant +: 32];
      pmem.outport_write_data_o = pmem.inport_write_data_i[32*grant +: 32];
    end
    if (fire) pmem.inport_accept_o[grant] = 1'b1;
  end

  always_comb begin
    lock_d      = req_g & ~fire;
    grant_d     = req_g ? grant : grant_q;
    burst_cnt_d = burst_cnt_q;
    if (fire && wr_g)
      burst_cnt_d = (burst_cnt_q == 8'd0) ? sel_len : burst_cnt_q - 8'd1;
  end

  dcache_pmem_arb_fifo #(.WIDTH(ENT_W), .DEPTH(OUTSTANDING)) u_id_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (push),
    .push_dat_i (push_dat),
    .pop_i      (pop),
    .head_dat_o (head_dat),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  assign head_id   = head_dat[ENT_W-1:9];
  assign head_acks = head_dat[8:0];
  assign head_last = (head_cnt_q == (head_acks - 9'd1));
  // Responses with nothing outstanding are dropped rather than routed.
  assign resp_vld  = (pmem.outport_ack_i | pmem.outport_error_i) & ~fifo_empty;
  assign pop       = resp_vld & head_last;
  assign head_cnt_d = resp_vld ? (head_last ? 9'd0 : head_cnt_q + 9'd1) : head_cnt_q;

  always_comb begin
    pmem.inport_ack_o   = '0;
    pmem.inport_error_o = '0;
    if (!fifo_empty) begin
      pmem.inport_ack_o[head_id]   = pmem.outport_ack_i;
      pmem.inport_error_o[head_id] = pmem.outport_error_i;
    end
    pmem.inport_read_data_o = {NUM_PORTS{pmem.outport_read_data_i}};
  end

`ifdef DCACHE_PMEM_ARB_RR_EN
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  assign rr_ptr   = rr_ptr_q;
  assign rr_ptr_d = push ? ((grant == ID_W'(NUM_PORTS-1)) ? '0 : grant + ID_W'(1)) : rr_ptr_q;
  always_ff @(posedge clk) begin
    if (!rst_n) rr_ptr_q <= '0;
    else        rr_ptr_q <= rr_ptr_d;
  end
`else
  assign rr_ptr = '0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lock_q      <= 1'b0;
      grant_q     <= '0;
      burst_cnt_q <= '0;
      head_cnt_q  <= '0;
    end else begin
      lock_q      <= lock_d;
      grant_q     <= grant_d;
      burst_cnt_q <= burst_cnt_d;
      head_cnt_q  <= head_cnt_d;
    end
  end
endmodule

// File: tb/tb_dcache_pmem_arb.sv
// Directed bench for dcache_pmem_arb: 2 ports, 4 outstanding; follows DCACHE_PMEM_ARB_RR_EN if defined.
module tb_dcache_pmem_arb;
  logic clk;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [1:0] exp6;

  dcache_pmem_arb_if #(.NUM_PORTS(2)) bus ();

  dcache_pmem_arb #(.NUM_PORTS(2), .ID_W(1), .OUTSTANDING(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .pmem  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_req();
    bus.inport_wr_i         = '0;
    bus.inport_rd_i         = '0;
    bus.inport_len_i        = '0;
    bus.inport_addr_i       = '0;
    bus.inport_write_data_i = '0;
  endtask

  task automatic set_rd(input int p, input logic [7:0] len, input logic [31:0] addr);
    bus.inport_rd_i[p]            = 1'b1;
    bus.inport_wr_i[4*p +: 4]     = 4'd0;
    bus.inport_len_i[8*p +: 8]    = len;
    bus.inport_addr_i[32*p +: 32] = addr;
  endtask

  task automatic set_wr(input int p, input logic [3:0] strb, input logic [7:0] len,
                        input logic [31:0] addr, input logic [31:0] data);
    bus.inport_rd_i[p]                  = 1'b0;
    bus.inport_wr_i[4*p +: 4]           = strb;
    bus.inport_len_i[8*p +: 8]          = len;
    bus.inport_addr_i[32*p +: 32]       = addr;
    bus.inport_write_data_i[32*p +: 32] = data;
  endtask

  initial begin
    rst_n = 1'b0;
    clear_req();
    bus.outport_accept_i    = 1'b0;
    bus.outport_ack_i       = 1'b1;
    bus.outport_error_i     = 1'b0;
    bus.outport_read_data_i = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rd_o", 64'(bus.outport_rd_o), 64'd0);
    check("rst_wr_o", 64'(bus.outport_wr_o), 64'd0);
    check("rst_addr_o", 64'(bus.outport_addr_o), 64'd0);
    check("rst_accept_o", 64'(bus.inport_accept_o), 64'd0);
    check("rst_ack_o_dropped", 64'(bus.inport_ack_o), 64'd0);
    rst_n = 1'b1;
    bus.outport_ack_i = 1'b0;
    tick();

    // 1: single read burst of 8 beats
    bus.outport_accept_i = 1'b1;
    set_rd(0, 8'd7, 32'h1000);
    #1;
    check("t1_rd_o", 64'(bus.outport_rd_o), 64'd1);
    check("t1_addr_o", 64'(bus.outport_addr_o), 64'h1000);
    check("t1_len_o", 64'(bus.outport_len_o), 64'd7);
    check("t1_accept", 64'(bus.inport_accept_o), 64'b01);
    tick();
    clear_req();
    #1;
    check("t1_accept_drop", 64'(bus.inport_accept_o), 64'b00);
    for (int i = 0; i < 8; i++) begin
      bus.outport_ack_i       = 1'b1;
      bus.outport_read_data_i = 32'hA0 + 32'(i);
      #1;
      check("t1_ack_o", 64'(bus.inport_ack_o), 64'b01);
      check("t1_rdata", 64'(bus.inport_read_data_o), {2{32'hA0 + 32'(i)}});
      tick();
    end
    #1;
    check("t1_late_ack_dropped", 64'(bus.inport_ack_o), 64'b00);
    tick();
    bus.outport_ack_i = 1'b0;

    // 2: P1 write burst of 4 holds off P0 read
    set_wr(1, 4'hF, 8'd3, 32'h2000, 32'hD0);
    #1;
    check("t2_b0_accept", 64'(bus.inport_accept_o), 64'b10);
    check("t2_b0_wr_o", 64'(bus.outport_wr_o), 64'hF);
    tick();
    for (int b = 1; b < 4; b++) begin
      set_wr(1, 4'hF, 8'd3, 32'h2000 + 32'(4*b), 32'hD0 + 32'(b));
      set_rd(0, 8'd1, 32'h3000);
      #1;
      check("t2_burst_accept", 64'(bus.inport_accept_o), 64'b10);
      check("t2_burst_addr", 64'(bus.outport_addr_o), 64'h2000 + 64'(4*b));
      check("t2_burst_data", 64'(bus.outport_write_data_o), 64'hD0 + 64'(b));
      check("t2_burst_rd_o", 64'(bus.outport_rd_o), 64'd0);
      tick();
    end
    bus.inport_wr_i = '0;
    #1;
    check("t2_p0_accept", 64'(bus.inport_accept_o), 64'b01);
    check("t2_p0_addr", 64'(bus.outport_addr_o), 64'h3000);
    tick();
    clear_req();
    bus.outport_ack_i = 1'b1;
    #1; check("t2_ack0_p1", 64'(bus.inport_ack_o), 64'b10); tick();
    #1; check("t2_ack1_p0", 64'(bus.inport_ack_o), 64'b01); tick();
    #1; check("t2_ack2_p0", 64'(bus.inport_ack_o), 64'b01); tick();
    bus.outport_ack_i = 1'b0;

    // 3: presented-but-unaccepted request keeps the grant
    bus.outport_accept_i = 1'b0;
    set_rd(1, 8'd0, 32'h4000);
    #1;
    check("t3_p1_addr", 64'(bus.outport_addr_o), 64'h4000);
    check("t3_accept_low", 64'(bus.inport_accept_o), 64'b00);
    tick();
    set_rd(0, 8'd0, 32'h5000);
    repeat (2) begin
      #1;
      check("t3_lock_addr", 64'(bus.outport_addr_o), 64'h4000);
      check("t3_lock_accept", 64'(bus.inport_accept_o), 64'b00);
      tick();
    end
    bus.outport_accept_i = 1'b1;
    #1;
    check("t3_p1_accept", 64'(bus.inport_accept_o), 64'b10);
    tick();
    bus.inport_rd_i[1] = 1'b0;
    #1;
    check("t3_p0_accept", 64'(bus.inport_accept_o), 64'b01);
    check("t3_p0_addr", 64'(bus.outport_addr_o), 64'h5000);
    tick();
    clear_req();
    bus.outport_ack_i = 1'b1;
    #1; check("t3_ack_p1", 64'(bus.inport_ack_o), 64'b10); tick();
    #1; check("t3_ack_p0", 64'(bus.inport_ack_o), 64'b01); tick();
    bus.outport_ack_i = 1'b0;

    // 4: FIFO full blocks the fifth read
    set_rd(0, 8'd0, 32'h6000);
    for (int i = 0; i < 4; i++) begin
      #1;
      check("t4_fill_accept", 64'(bus.inport_accept_o), 64'b01);
      tick();
    end
    #1;
    check("t4_full_accept", 64'(bus.inport_accept_o), 64'b00);
    check("t4_full_rd_o", 64'(bus.outport_rd_o), 64'd0);
    tick();
    bus.outport_ack_i = 1'b1;
    #1;
    check("t4_pop_ack", 64'(bus.inport_ack_o), 64'b01);
    check("t4_pop_no_push", 64'(bus.inport_accept_o), 64'b00);
    tick();
    bus.outport_ack_i = 1'b0;
    #1;
    check("t4_after_pop_accept", 64'(bus.inport_accept_o), 64'b01);
    tick();
    clear_req();
    bus.outport_ack_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("t4_drain_ack", 64'(bus.inport_ack_o), 64'b01);
      tick();
    end
    #1;
    check("t4_empty_ack", 64'(bus.inport_ack_o), 64'b00);
    tick();
    bus.outport_ack_i = 1'b0;

    // 5: error beat counts toward the response total
    set_rd(1, 8'd3, 32'h7000);
    #1;
    check("t5_accept", 64'(bus.inport_accept_o), 64'b10);
    tick();
    clear_req();
    for (int i = 0; i < 4; i++) begin
      bus.outport_ack_i   = (i != 1);
      bus.outport_error_i = (i == 1);
      #1;
      check("t5_ack_o", 64'(bus.inport_ack_o), (i != 1) ? 64'b10 : 64'b00);
      check("t5_err_o", 64'(bus.inport_error_o), (i == 1) ? 64'b10 : 64'b00);
      tick();
    end
    bus.outport_ack_i   = 1'b1;
    bus.outport_error_i = 1'b0;
    #1;
    check("t5_popped", 64'(bus.inport_ack_o), 64'b00);
    tick();
    bus.outport_ack_i = 1'b0;

    // 6: both ports streaming single reads
    set_rd(0, 8'd0, 32'h8000);
    set_rd(1, 8'd0, 32'h9000);
    for (int i = 0; i < 4; i++) begin
`ifdef DCACHE_PMEM_ARB_RR_EN
      exp6 = (i % 2 == 1) ? 2'b10 : 2'b01;
`else
      exp6 = 2'b01;
`endif
      #1;
      check("t6_grant", 64'(bus.inport_accept_o), 64'(exp6));
      tick();
    end
    clear_req();
    bus.outport_ack_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
`ifdef DCACHE_PMEM_ARB_RR_EN
      exp6 = (i % 2 == 1) ? 2'b10 : 2'b01;
`else
      exp6 = 2'b01;
`endif
      #1;
      check("t6_ack_route", 64'(bus.inport_ack_o), 64'(exp6));
      tick();
    end
    bus.outport_ack_i = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
